// File: rtl/pe_dot_accumulator_if.sv
// Bundles the product stream, the fpu_adder strobe bus and the result port
// of the PE dot-product sequencer.
interface pe_dot_accumulator_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      prod_data;
    logic             prod_valid;
    logic             prod_last;
    logic             prod_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_a_stb;
    logic             add_b_stb;
    logic [31:0]      add_z;
    logic             add_z_stb;
    logic [31:0]      res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    // slave: the accumulator itself; master: whoever feeds products,
    // models the adder and sinks results.
    modport slave (
        input  prod_data, prod_valid, prod_last, add_z, add_z_stb, res_ready,
        output prod_ready, add_a, add_b, add_a_stb, add_b_stb,
               res_data, res_count, res_valid, busy
    );

    modport master (
        output prod_data, prod_valid, prod_last, add_z, add_z_stb, res_ready,
        input  prod_ready, add_a, add_b, add_a_stb, add_b_stb,
               res_data, res_count, res_valid, busy
    );
endinterface

// File: rtl/pe_dot_accumulator.sv
// Dot-product sequencer: folds a stream of single-precision products into a
// running sum through an external fpu_adder, one add outstanding at a time.
module pe_dot_accumulator #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_dot_accumulator_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_q;

    assign cnt_inc        = (&cnt) ? cnt : cnt + 1'b1;
    assign bus.prod_ready = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            acc           <= ACC_INIT;
            cnt           <= '0;
            last_q        <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_a_stb <= 1'b0;
            bus.add_b_stb <= 1'b0;
            bus.res_data  <= '0;
            bus.res_count <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.prod_valid) begin
                        bus.add_a     <= acc;
                        bus.add_b     <= bus.prod_data;
                        last_q        <= bus.prod_last;
                        bus.add_a_stb <= 1'b1;
                        bus.add_b_stb <= 1'b1;
                        state         <= S_ADD;
                    end
                end
                S_ADD: begin
                    // Strobes stay up until the sum returns; dropping them on
                    // that edge keeps the re-armed adder from capturing twice.
                    if (bus.add_z_stb) begin
                        acc           <= bus.add_z;
                        cnt           <= cnt_inc;
                        bus.add_a_stb <= 1'b0;
                        bus.add_b_stb <= 1'b0;
                        if (last_q) begin
                            bus.res_data  <= bus.add_z;
                            bus.res_count <= cnt_inc;
                            bus.res_valid <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        acc           <= ACC_INIT;
                        cnt           <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_dot_accumulator.sv
// Directed and randomized checks of pe_dot_accumulator against a behavioural
// fpu_adder with variable latency and a real-arithmetic reference sum.
module tb_pe_dot_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_dot_accumulator_if #(.CNT_W(16)) bus ();
    pe_dot_accumulator #(.CNT_W(16), .ACC_INIT(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nasrt = 0;
    int nfail = 0;
    int lat = 1;
    int hold_err = 0;
    logic [31:0] terms[$];
    logic [31:0] cap_a[$];
    logic [31:0] cap_b[$];

    // Single-precision helpers: exact for normal values whose sums stay representable.
    function automatic real f2r(input logic [31:0] f);
        real v;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  a;
        int   e;
        logic s;
        int   m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 8388608.0);
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Adder model: captures when armed and both strobes high, answers after
    // lat cycles with a one-cycle z strobe, re-arms one cycle later.
    logic [1:0]  ast;
    int          cd;
    logic [31:0] za, zb;
    always @(posedge clk) begin
        if (rst) begin
            ast           <= 2'd0;
            bus.add_z_stb <= 1'b0;
            bus.add_z     <= 32'h0;
        end else begin
            bus.add_z_stb <= 1'b0;
            if (ast != 2'd0 && !(bus.add_a_stb && bus.add_b_stb && bus.add_a == za && bus.add_b == zb))
                hold_err++;
            case (ast)
                2'd0: if (bus.add_a_stb && bus.add_b_stb) begin
                    za <= bus.add_a;
                    zb <= bus.add_b;
                    cap_a.push_back(bus.add_a);
                    cap_b.push_back(bus.add_b);
                    cd  <= lat;
                    ast <= 2'd1;
                end
                2'd1: if (cd == 0) begin
                    bus.add_z     <= fadd(za, zb);
                    bus.add_z_stb <= 1'b1;
                    ast           <= 2'd2;
                end else cd <= cd - 1;
                default: ast <= 2'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        bus.prod_data  = d;
        bus.prod_last  = l;
        bus.prod_valid = 1'b1;
        @(negedge clk);
        while (!bus.prod_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("prod_ready_timeout", bus.prod_ready, 1);
        @(posedge clk);
        #1 bus.prod_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 300) begin @(negedge clk); n++; end
        chk("res_valid_arrives", bus.res_valid, 1);
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'h0;
        foreach (terms[i]) s = fadd(s, terms[i]);
        return s;
    endfunction

    // Streams terms[], then checks the adder operands, the result and the hand-off.
    task automatic run_dot(input logic [31:0] want, input bit rand_lat);
        logic [31:0] s;
        int          nterm;
        int          stall;
        cap_a.delete();
        cap_b.delete();
        hold_err = 0;
        nterm = terms.size();
        foreach (terms[i]) begin
            lat = rand_lat ? int'($urandom_range(0, 3)) : 1;
            send(terms[i], i == nterm - 1);
        end
        wait_res();
        chk("res_data", bus.res_data, want);
        chk("res_count", bus.res_count, nterm);
        chk("busy_in_done", bus.busy, 1);
        chk("prod_ready_in_done", bus.prod_ready, 0);
        chk("adds_issued", cap_a.size(), nterm);
        chk("strobe_hold", hold_err, 0);
        s = 32'h0;
        for (int i = 0; i < nterm && i < cap_a.size(); i++) begin
            chk("add_a_running_sum", cap_a[i], s);
            chk("add_b_product", cap_b[i], terms[i]);
            s = fadd(s, terms[i]);
        end
        stall = rand_lat ? int'($urandom_range(0, 4)) : 0;
        repeat (stall) @(negedge clk);
        chk("res_valid_held", bus.res_valid, 1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        chk("res_valid_cleared", bus.res_valid, 0);
        chk("res_data_kept", bus.res_data, want);
        chk("busy_after_handoff", bus.busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.prod_data  = 32'h0;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_add_a_stb", bus.add_a_stb, 0);
        chk("rst_add_b_stb", bus.add_b_stb, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_b", bus.add_b, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_count", bus.res_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_prod_ready", bus.prod_ready, 1);
        rst = 1'b0;

        terms = '{32'h3F800000, 32'h40000000, 32'h40400000};
        run_dot(32'h40C00000, 0);
        terms = '{32'hC0490FDB};
        run_dot(32'hC0490FDB, 0);
        terms = '{32'hBFC00000, 32'h3FC00000};
        run_dot(32'h00000000, 0);
        terms = '{32'h7F800000, 32'h3F800000};
        run_dot(32'h7F800000, 0);
        terms = '{32'h40000000};
        run_dot(32'h40000000, 0);

        // Backpressure: a waiting product must not be consumed while the result is held.
        cap_a.delete();
        cap_b.delete();
        lat = 2;
        send(32'h3F800000, 1'b1);
        wait_res();
        bus.prod_data  = 32'h40000000;
        bus.prod_last  = 1'b1;
        bus.prod_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_data", bus.res_data, 32'h3F800000);
            chk("bp_prod_ready", bus.prod_ready, 0);
        end
        chk("bp_no_extra_add", cap_a.size(), 1);
        bus.prod_valid = 1'b0;
        bus.res_ready  = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        chk("bp_released", bus.res_valid, 0);

        // Reset while an add is outstanding.
        lat = 6;
        send(32'h3F800000, 1'b0);
        @(posedge clk);
        #1 chk("pre_rst_in_add", bus.add_a_stb, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_add_a_stb", bus.add_a_stb, 0);
        chk("midrst_add_b_stb", bus.add_b_stb, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        terms = '{32'h40400000};
        run_dot(32'h40400000, 0);

        // Random integer-valued dot products with random adder latency and backpressure.
        for (int k = 0; k < 8; k++) begin
            int len;
            terms.delete();
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++)
                terms.push_back(r2f(real'(int'($urandom_range(0, 100)) - 50)));
            run_dot(model_sum(), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end
endmodule
